// File: rtl/serial_pkg.sv
// Shared serial-link types and constants for the transmit arbiter and the serial receiver.
package serial_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } serial_state_e;

  localparam int CLK_HZ          = 50_000_000;
  localparam int BAUD            = 9600;
  localparam int DEFAULT_DIVISOR = 5208;
  localparam int DATA_BITS       = 8;

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request scanning upward from i_ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_pick,
  output logic [PW-1:0]   o_id,
  output logic            o_valid
);

  // scan order starts at the pointer; the first hit wins and masks later ones
  always_comb begin
    o_pick  = '0;
    o_id    = '0;
    o_valid = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      int   w_sum;
      int   w_idx;
      logic w_hit;
      w_sum          = int'(i_ptr) + i;
      w_idx          = (w_sum >= NREQ) ? (w_sum - NREQ) : w_sum;
      w_hit          = !o_valid && i_req[w_idx];
      o_pick[w_idx]  = o_pick[w_idx] | w_hit;
      o_id           = w_hit ? w_idx[PW-1:0] : o_id;
      o_valid        = o_valid | w_hit;
    end
  end

endmodule

// File: rtl/serial_tx_arbiter.sv
// Round-robin shared 8N1 serial transmitter; define SERIAL_TX_PARITY_EN to add an even-parity bit.
module serial_tx_arbiter
  import serial_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DIVISOR = 5208,
  parameter int DIV_W   = 13
) (
  input  logic                     m_clock,
  input  logic                     p_reset,
  input  logic [NREQ-1:0]          req,
  input  logic [8*NREQ-1:0]        data,
  output logic [NREQ-1:0]          grant,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy,
  output logic                     TXD
);

  localparam int PW = $clog2(NREQ);
`ifdef SERIAL_TX_PARITY_EN
  localparam serial_state_e S_AFTER_DATA = S_PARITY;
`else
  localparam serial_state_e S_AFTER_DATA = S_STOP;
`endif

  serial_state_e   r_state;
  serial_state_e   w_state_nxt;
  logic [DIV_W-1:0] r_div;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_gid;
  logic [NREQ-1:0] r_grant;
  logic            r_txd;
  logic            r_busy;
`ifdef SERIAL_TX_PARITY_EN
  logic            r_par;
`endif

  logic            w_wrap;
  logic            w_take;
  logic            w_valid;
  logic            w_txd_nxt;
  logic [NREQ-1:0] w_pick;
  logic [PW-1:0]   w_pid;
  logic [7:0]      w_byte;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_pick  (w_pick),
    .o_id    (w_pid),
    .o_valid (w_valid)
  );

  assign w_wrap = (r_div == DIV_W'(DIVISOR - 1));
  // arbitration opens only in IDLE or on the last cycle of STOP
  assign w_take = w_valid && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_wrap));
  assign w_byte = data[{w_pid, 3'b000} +: 8];

  // state register
  always_ff @(posedge m_clock) begin
    if (!p_reset) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   w_state_nxt = w_valid ? S_START : S_IDLE;
      S_START:  w_state_nxt = w_wrap ? S_DATA : S_START;
      S_DATA:   w_state_nxt = (w_wrap && (r_bit == 3'd7)) ? S_AFTER_DATA : S_DATA;
      S_PARITY: w_state_nxt = w_wrap ? S_STOP : S_PARITY;
      S_STOP:   w_state_nxt = w_wrap ? (w_valid ? S_START : S_IDLE) : S_STOP;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // line level for the next cycle; r_shift[1] is the bit that becomes LSB after this wrap
  always_comb begin
    w_txd_nxt = r_txd;
    case (r_state)
      S_IDLE:   w_txd_nxt = !w_valid;
      S_START:  w_txd_nxt = w_wrap ? r_shift[0] : r_txd;
`ifdef SERIAL_TX_PARITY_EN
      S_DATA:   w_txd_nxt = w_wrap ? ((r_bit == 3'd7) ? r_par : r_shift[1]) : r_txd;
`else
      S_DATA:   w_txd_nxt = w_wrap ? ((r_bit == 3'd7) ? 1'b1 : r_shift[1]) : r_txd;
`endif
      S_PARITY: w_txd_nxt = w_wrap ? 1'b1 : r_txd;
      S_STOP:   w_txd_nxt = w_wrap ? !w_valid : r_txd;
      default:  w_txd_nxt = 1'b1;
    endcase
  end

  // datapath: divider, bit counter, shifter, grant and pointer
  always_ff @(posedge m_clock) begin
    if (!p_reset) begin
      r_div   <= '0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_ptr   <= '0;
      r_gid   <= '0;
      r_grant <= '0;
      r_txd   <= 1'b1;
      r_busy  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_txd  <= w_txd_nxt;
      r_busy <= (w_state_nxt != S_IDLE);
      r_div  <= ((r_state == S_IDLE) || w_wrap) ? '0 : r_div + DIV_W'(1);
      r_bit  <= (r_state != S_DATA) ? 3'd0 : (w_wrap ? r_bit + 3'd1 : r_bit);
      if (w_take) begin
        r_shift <= w_byte;
        r_grant <= w_pick;
        r_gid   <= w_pid;
        r_ptr   <= (w_pid == PW'(NREQ - 1)) ? '0 : w_pid + PW'(1);
`ifdef SERIAL_TX_PARITY_EN
        r_par   <= even_parity(w_byte);
`endif
      end else begin
        r_grant <= '0;
        r_shift <= ((r_state == S_DATA) && w_wrap) ? {1'b0, r_shift[7:1]} : r_shift;
      end
    end
  end

  assign grant    = r_grant;
  assign grant_id = r_gid;
  assign busy     = r_busy;
  assign TXD      = r_txd;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Self-checking bench for serial_tx_arbiter with a frame-level reference model (DIVISOR=4, NREQ=4).
module tb_serial_tx_arbiter;

  localparam int NREQ = 4;
  localparam int DIV  = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * DIV;

  logic        m_clock = 1'b0;
  logic        p_reset = 1'b0;
  logic [3:0]  req     = 4'b0000;
  logic [31:0] data    = 32'h0;
  wire  [3:0]  grant;
  wire  [1:0]  grant_id;
  wire         busy;
  wire         TXD;

  int checks = 0;
  int errors = 0;

  serial_tx_arbiter #(.NREQ(NREQ), .DIVISOR(DIV), .DIV_W(3)) dut (
    .m_clock  (m_clock),
    .p_reset  (p_reset),
    .req      (req),
    .data     (data),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .TXD      (TXD)
  );

  always #5 m_clock = ~m_clock;

  // reference model: a frame is a list of line levels indexed by elapsed/DIV
  logic        m_active = 1'b0;
  int          m_el     = 0;
  int          m_ptr    = 0;
  logic [3:0]  m_grant  = 4'b0000;
  logic [1:0]  m_gid    = 2'd0;
  logic [10:0] m_bits   = 11'h7FF;
  wire         m_txd    = m_active ? m_bits[m_el / DIV] : 1'b1;

  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int i = 0; i < NREQ; i++) begin
      if (r[(p + i) % NREQ]) return (p + i) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [10:0] frame_bits(input logic [7:0] b);
    logic [10:0] f;
    f = 11'h7FF;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1 + i] = b[i];
`ifdef SERIAL_TX_PARITY_EN
    f[9] = ^b;
`endif
    return f;
  endfunction

  always @(posedge m_clock) begin
    if (!p_reset) begin
      m_active <= 1'b0;
      m_el     <= 0;
      m_ptr    <= 0;
      m_gid    <= 2'd0;
      m_grant  <= 4'b0000;
    end else if ((!m_active || (m_el == FRAME - 1)) && (req != 4'b0000)) begin
      m_grant  <= 4'b0001 << rr_pick(req, m_ptr);
      m_gid    <= 2'(rr_pick(req, m_ptr));
      m_bits   <= frame_bits(data[8 * rr_pick(req, m_ptr) +: 8]);
      m_el     <= 0;
      m_active <= 1'b1;
      m_ptr    <= (rr_pick(req, m_ptr) + 1) % NREQ;
    end else begin
      m_grant <= 4'b0000;
      if (m_active && (m_el == FRAME - 1)) m_active <= 1'b0;
      else if (m_active)                   m_el <= m_el + 1;
    end
  end

  task automatic tick();
    @(posedge m_clock);
    #1;
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic hard_reset();
    p_reset = 1'b0;
    tick();
    p_reset = 1'b1;
  endtask

  task automatic test_reset();
    req  = 4'b1111;
    data = $urandom;
    p_reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({TXD, grant, busy} !== {1'b1, 4'b0000, 1'b0}) begin
        errors++;
        $display("FAIL reset_hold c=%0d got %b exp %b", c, {TXD, grant, busy}, {1'b1, 4'b0000, 1'b0});
      end
    end
    p_reset = 1'b1;
    tick();
    checks++;
    if ({grant, grant_id, TXD} !== {4'b0001, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_first_grant got %b exp %b", {grant, grant_id, TXD}, {4'b0001, 2'd0, 1'b0});
    end
    req = 4'b0000;
    idle_ticks(FRAME + 2);
  endtask

  task automatic test_single_frame();
    logic [10:0] pat;
`ifdef SERIAL_TX_PARITY_EN
    pat = {1'b1, 1'b0, 8'hA5, 1'b0};
`else
    pat = {1'b1, 10'b1101001010};
`endif
    data = {$urandom} & 32'hFF00_FFFF | 32'h00A5_0000;
    req  = 4'b0100;
    tick();
    req = 4'b0000;
    checks++;
    if ({grant, grant_id} !== {4'b0100, 2'd2}) begin
      errors++;
      $display("FAIL single_grant got %b exp %b", {grant, grant_id}, {4'b0100, 2'd2});
    end
    for (int c = 0; c < FRAME; c++) begin
      if (c > 0) tick();
      checks++;
      if ({TXD, busy} !== {pat[c / DIV], 1'b1}) begin
        errors++;
        $display("FAIL single_txd c=%0d got %b exp %b", c, {TXD, busy}, {pat[c / DIV], 1'b1});
      end
      checks++;
      if ({TXD, busy, grant, grant_id} !== {m_txd, m_active, m_grant, m_gid}) begin
        errors++;
        $display("FAIL single_model c=%0d got %b exp %b", c, {TXD, busy, grant, grant_id}, {m_txd, m_active, m_grant, m_gid});
      end
    end
    tick();
    checks++;
    if ({busy, TXD} !== 2'b01) begin
      errors++;
      $display("FAIL single_busy_fall got %b exp %b", {busy, TXD}, 2'b01);
    end
  endtask

  task automatic test_round_robin();
    logic       txd_log [5 * FRAME];
    logic       all_busy;
    int         gids [$];
    logic [7:0] b;
    logic [7:0] exp_b;
    hard_reset();
    data = 32'h4433_2211;
    req  = 4'b1111;
    all_busy = 1'b1;
    for (int c = 0; c < 5 * FRAME; c++) begin
      tick();
      txd_log[c] = TXD;
      all_busy = all_busy & busy;
      if (grant != 4'b0000) gids.push_back(int'(grant_id));
      checks++;
      if ({TXD, busy, grant, grant_id} !== {m_txd, m_active, m_grant, m_gid}) begin
        errors++;
        $display("FAIL rr_model c=%0d got %b exp %b", c, {TXD, busy, grant, grant_id}, {m_txd, m_active, m_grant, m_gid});
      end
    end
    req = 4'b0000;
    checks++;
    if (all_busy !== 1'b1) begin
      errors++;
      $display("FAIL rr_no_gap got busy_all=%b exp 1", all_busy);
    end
    checks++;
    if (gids.size() != 5) begin
      errors++;
      $display("FAIL rr_grant_count got %0d exp 5", gids.size());
    end
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < 8; i++) b[i] = txd_log[f * FRAME + (i + 1) * DIV + DIV / 2];
      exp_b = 8'h11 * 8'((f % 4) + 1);
      checks++;
      if ({txd_log[f * FRAME + DIV / 2], b, txd_log[f * FRAME + (NBITS - 1) * DIV + DIV / 2]} !== {1'b0, exp_b, 1'b1}) begin
        errors++;
        $display("FAIL rr_decode f=%0d got byte %h exp %h", f, b, exp_b);
      end
      if (f < gids.size()) begin
        checks++;
        if (gids[f] != f % 4) begin
          errors++;
          $display("FAIL rr_order f=%0d got %0d exp %0d", f, gids[f], f % 4);
        end
      end
    end
    idle_ticks(FRAME + 2);
  endtask

  task automatic test_mid_frame();
    data = $urandom;
    req  = 4'b0001;
    for (int c = 0; c <= FRAME; c++) begin
      tick();
      checks++;
      if ({TXD, busy, grant, grant_id} !== {m_txd, m_active, m_grant, m_gid}) begin
        errors++;
        $display("FAIL mid_model c=%0d got %b exp %b", c, {TXD, busy, grant, grant_id}, {m_txd, m_active, m_grant, m_gid});
      end
      checks++;
      if (grant !== ((c == 0) ? 4'b0001 : (c == FRAME) ? 4'b1000 : 4'b0000)) begin
        errors++;
        $display("FAIL mid_grant c=%0d got %b", c, grant);
      end
      if (c == 10) req = 4'b1001;
    end
    req = 4'b0000;
    idle_ticks(FRAME + 2);
  endtask

  task automatic test_withdraw_abort();
    logic seen1;
    seen1 = 1'b0;
    data  = $urandom;
    req   = 4'b0001;
    for (int c = 0; c < FRAME + 6; c++) begin
      tick();
      seen1 = seen1 | grant[1];
      checks++;
      if ({TXD, busy, grant, grant_id} !== {m_txd, m_active, m_grant, m_gid}) begin
        errors++;
        $display("FAIL withdraw_model c=%0d got %b exp %b", c, {TXD, busy, grant, grant_id}, {m_txd, m_active, m_grant, m_gid});
      end
      req = (c >= 5 && c < 20) ? 4'b0010 : 4'b0000;
    end
    checks++;
    if (seen1 !== 1'b0) begin
      errors++;
      $display("FAIL withdraw_granted got %b exp 0", seen1);
    end
    req = 4'b0100;
    tick();
    req = 4'b0000;
    idle_ticks(14);
    p_reset = 1'b0;
    tick();
    checks++;
    if ({TXD, busy, grant} !== {1'b1, 1'b0, 4'b0000}) begin
      errors++;
      $display("FAIL abort_txd got %b exp %b", {TXD, busy, grant}, {1'b1, 1'b0, 4'b0000});
    end
    p_reset = 1'b1;
    for (int c = 0; c < 2 * DIV; c++) begin
      tick();
      checks++;
      if ({TXD, busy, grant} !== {1'b1, 1'b0, 4'b0000}) begin
        errors++;
        $display("FAIL abort_idle c=%0d got %b", c, {TXD, busy, grant});
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i]) data[8 * i +: 8] = 8'($urandom);
      end
      req = req | 4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
      if ($urandom_range(0, 31) == 0) req = req & 4'($urandom);
      tick();
      checks++;
      if ({TXD, busy, grant, grant_id} !== {m_txd, m_active, m_grant, m_gid}) begin
        errors++;
        $display("FAIL random_model c=%0d got %b exp %b", c, {TXD, busy, grant, grant_id}, {m_txd, m_active, m_grant, m_gid});
      end
      req = req & ~grant;
    end
    req = 4'b0000;
    idle_ticks(FRAME + 2);
  endtask

`ifdef SERIAL_TX_PARITY_EN
  task automatic test_parity();
    logic [7:0] bytes [2];
    logic       par_exp [2];
    bytes[0] = 8'h07; par_exp[0] = 1'b1;
    bytes[1] = 8'h03; par_exp[1] = 1'b0;
    for (int t = 0; t < 2; t++) begin
      data = {24'h0, bytes[t]};
      req  = 4'b0001;
      for (int c = 0; c <= FRAME; c++) begin
        tick();
        req = 4'b0000;
        if (c == 9 * DIV + DIV / 2) begin
          checks++;
          if (TXD !== par_exp[t]) begin
            errors++;
            $display("FAIL parity_bit t=%0d got %b exp %b", t, TXD, par_exp[t]);
          end
        end
        checks++;
        if (busy !== (c < FRAME)) begin
          errors++;
          $display("FAIL parity_len t=%0d c=%0d got busy %b", t, c, busy);
        end
      end
      idle_ticks(2);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_mid_frame();
    test_withdraw_abort();
    test_random();
`ifdef SERIAL_TX_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
